// File: rtl/norm2_pkg.sv
// Shared constants, types and FSM state encoding for the norm2 kernel loader.
package norm2_pkg;

  localparam int unsigned N      = 1000;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 27;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned CNT_W  = 11;

  typedef logic        [ADDR_W-1:0] addr_t;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {IDLE, LOAD, FILL, START, RUN, OUT} loader_state_t;

  localparam addr_t LAST_ADDR = addr_t'(N - 1);

endpackage

// File: rtl/norm2_loader.sv
// Streams a sample frame into the norm2 kernel array, runs the kernel and returns its result.
// Optional: define NORM2_LOADER_CYCLE_COUNT_EN to add the m_cycles run-length output.
module norm2_loader
  import norm2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              r_enable,
  output logic [ADDR_W-1:0] init_i_t_a,
  output logic [ACC_W-1:0]  init_acc_t_a,
  output logic              controlArr,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrWData_a,
  input  logic [DATA_W-1:0] controlArrRData_a,
  input  logic              w_enable,
  input  logic [ACC_W-1:0]  result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_data,
  output logic [CNT_W-1:0]  m_count,
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
  output logic [31:0]       m_cycles,
`endif
  output logic              busy
);

  loader_state_t          state;
  addr_t                  addr;
  logic [CNT_W-1:0]       count;
  logic                   run_first;
  logic                   load_ph;
  logic                   beat;
  logic                   unused_rdata;
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
  logic [31:0]            cycles;
`endif

  assign unused_rdata = ^controlArrRData_a;

  assign load_ph = (state == IDLE) || (state == LOAD);
  // Gated by rst so every output reads 0 while reset is held.
  assign s_ready    = load_ph & ~rst;
  assign controlArr = (load_ph || (state == FILL)) & ~rst;
  assign beat       = s_valid & s_ready;

  assign controlArrWEnable_a = (load_ph & beat) | (state == FILL);
  assign controlArrAddr_a    = addr;
  assign controlArrWData_a   = (state == FILL) ? '0 : s_data;

  assign init_i_t_a   = '0;
  assign init_acc_t_a = '0;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      run_first <= 1'b0;
      r_enable  <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_count   <= '0;
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
      cycles    <= '0;
      m_cycles  <= '0;
`endif
    end else begin
      r_enable <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (beat) begin
            count <= (state == IDLE) ? CNT_W'(1) : count + 1'b1;
            // A beat at the top address ends the frame regardless of s_last.
            if (addr == LAST_ADDR) begin
              addr     <= '0;
              state    <= START;
              r_enable <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= s_last ? FILL : LOAD;
            end
          end
        end
        FILL: begin
          if (addr == LAST_ADDR) begin
            addr     <= '0;
            state    <= START;
            r_enable <= 1'b1;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        START: begin
          state     <= RUN;
          run_first <= 1'b1;
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
          cycles    <= 32'd1;
`endif
        end
        RUN: begin
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
          if (cycles != '1) cycles <= cycles + 1'b1;
`endif
          // w_enable from the previous run may still be high in the first RUN cycle.
          if (run_first) begin
            run_first <= 1'b0;
          end else if (w_enable) begin
            m_data  <= result;
            m_count <= count;
            m_valid <= 1'b1;
            state   <= OUT;
`ifdef NORM2_LOADER_CYCLE_COUNT_EN
            m_cycles <= (cycles == '1) ? cycles : cycles + 1'b1;
`endif
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm2_loader.sv
// Directed bench for norm2_loader with a behavioural norm2 kernel model.
module tb_norm2_loader;
  import norm2_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              r_enable;
  logic [ADDR_W-1:0] init_i_t_a;
  logic [ACC_W-1:0]  init_acc_t_a;
  logic              controlArr;
  logic              controlArrWEnable_a;
  logic [ADDR_W-1:0] controlArrAddr_a;
  logic [DATA_W-1:0] controlArrWData_a;
  logic [DATA_W-1:0] controlArrRData_a;
  logic              w_enable = 1'b1;
  logic [ACC_W-1:0]  result = 64'd777;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [ACC_W-1:0]  m_data;
  logic [CNT_W-1:0]  m_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  norm2_loader dut (
    .clk                 (clk),
    .rst                 (rst),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .s_data              (s_data),
    .s_last              (s_last),
    .r_enable            (r_enable),
    .init_i_t_a          (init_i_t_a),
    .init_acc_t_a        (init_acc_t_a),
    .controlArr          (controlArr),
    .controlArrWEnable_a (controlArrWEnable_a),
    .controlArrAddr_a    (controlArrAddr_a),
    .controlArrWData_a   (controlArrWData_a),
    .controlArrRData_a   (controlArrRData_a),
    .w_enable            (w_enable),
    .result              (result),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_data              (m_data),
    .m_count             (m_count),
    .busy                (busy)
  );

  // Kernel model: array starts with junk; w_enable lingers one cycle after r_enable.
  longint mem [N];
  int     kcnt   = 0;
  logic   kstart = 1'b0;

  initial for (int i = 0; i < int'(N); i++) mem[i] = 1000;

  assign controlArrRData_a = DATA_W'(mem[controlArrAddr_a]);

  always @(posedge clk) begin
    longint acc;
    if (controlArr && controlArrWEnable_a)
      mem[controlArrAddr_a] <= longint'($signed(controlArrWData_a));
    if (r_enable) begin
      kstart <= 1'b1;
    end else if (kstart) begin
      kstart   <= 1'b0;
      w_enable <= 1'b0;
      kcnt     <= 8;
    end else if (kcnt > 0) begin
      if (kcnt == 1) begin
        acc = 0;
        for (int i = int'(init_i_t_a); i < int'(N); i++) acc += mem[i] * mem[i];
        result   <= acc + init_acc_t_a;
        w_enable <= 1'b1;
      end
      kcnt <= kcnt - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input int len, input int v0, input int v1, input int v2,
                            input bit with_last);
    for (int i = 0; i < len; i++) begin
      int wait_cnt;
      s_valid = 1'b1;
      s_data  = DATA_W'((i == 0) ? v0 : (i == 1) ? v1 : v2);
      s_last  = with_last && (i == len - 1);
      wait_cnt = 0;
      while (!s_ready && wait_cnt < 3000) begin
        tick();
        wait_cnt++;
      end
      if (!s_ready) check("s_ready_timeout", 0, 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int wait_cnt = 0;
    while (!m_valid && wait_cnt < 3000) begin
      tick();
      wait_cnt++;
    end
    if (!m_valid) check({name, "_m_valid_timeout"}, 0, 1);
  endtask

  task automatic collect(input string name, input longint exp_data, input int exp_count);
    wait_valid(name);
    check({name, "_m_data"}, longint'(m_data), exp_data);
    check({name, "_m_count"}, longint'(m_count), longint'(exp_count));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check({name, "_m_valid_clr"}, longint'(m_valid), 0);
    check({name, "_s_ready_idle"}, longint'(s_ready), 1);
    check({name, "_busy_idle"}, longint'(busy), 0);
  endtask

  typedef struct {
    string  name;
    int     len;
    int     v0;
    int     v1;
    int     v2;
    longint exp_data;
    int     exp_count;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{"full",    1000, 3, 3, 3, 64'd9000, 1000};
    vecs[1] = '{"short",   3, 1, 2, 3, 64'd14, 3};
    vecs[2] = '{"extreme", 1, -67108864, 0, 0, 64'd4503599627370496, 1};
    vecs[3] = '{"b2b_1",   1, 2, 0, 0, 64'd4, 1};
    vecs[4] = '{"b2b_2",   1, 4, 0, 0, 64'd16, 1};

    tick();
    tick();
    check("rst_busy", longint'(busy), 0);
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_r_enable", longint'(r_enable), 0);
    check("rst_wen", longint'(controlArrWEnable_a), 0);
    check("rst_m_data", longint'(m_data), 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", longint'(s_ready), 1);
    check("idle_controlArr", longint'(controlArr), 1);

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].len, vecs[k].v0, vecs[k].v1, vecs[k].v2, 1'b1);
      if (vecs[k].len == int'(N)) begin
        check({vecs[k].name, "_skip_fill_r_enable"}, longint'(r_enable), 1);
        check({vecs[k].name, "_start_controlArr"}, longint'(controlArr), 0);
      end else begin
        check({vecs[k].name, "_fill_wen"}, longint'(controlArrWEnable_a), 1);
        check({vecs[k].name, "_fill_addr"}, longint'(controlArrAddr_a),
              longint'(vecs[k].len));
        check({vecs[k].name, "_fill_wdata"}, longint'(controlArrWData_a), 0);
        check({vecs[k].name, "_fill_s_ready"}, longint'(s_ready), 0);
      end
      collect(vecs[k].name, vecs[k].exp_data, vecs[k].exp_count);
    end

    // Backpressure: result must hold for 20 cycles with m_ready low.
    send_frame(3, 1, 2, 3, 1'b1);
    wait_valid("bp");
    for (int c = 0; c < 20; c++) begin
      tick();
      check("bp_m_valid", longint'(m_valid), 1);
      check("bp_m_data", longint'(m_data), 14);
      check("bp_s_ready", longint'(s_ready), 0);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("bp_m_valid_clr", longint'(m_valid), 0);
    check("bp_s_ready_idle", longint'(s_ready), 1);

    // Reset in the middle of a load; leftover 7s must be zero-filled by the next frame.
    send_frame(500, 7, 7, 7, 1'b0);
    check("mid_load_busy", longint'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_r_enable", longint'(r_enable), 0);
    tick();
    rst = 1'b0;
    #1;
    send_frame(2, 5, 5, 5, 1'b1);
    collect("after_rst", 64'd50, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
